// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  // Controller FSM states; the encoding is visible on the debug state port.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_ENTRY    = 2'd1,
    ST_RETURN   = 2'd2,
    ST_INT_WAIT = 2'd3
  } state_e;

  // Next-PC select codes.
  localparam logic [1:0] PC_SEQ     = 2'd0;
  localparam logic [1:0] PC_HANDLER = 2'd1;
  localparam logic [1:0] PC_EPC     = 2'd2;

  // Exception handler entry address selected by PC_HANDLER.
  localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;

  // M-stage exception code meaning "no exception".
  localparam logic [4:0] EXC_NONE = 5'd0;

  // True when the M-stage exception code reports an exception.
  function automatic logic has_exc(input logic [4:0] exc_code);
    return exc_code != EXC_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side bundle of hazard inputs and sequencing outputs.
interface pipe_ctrl_if;
  logic       hazard_stall;
  logic       mdu_start;
  logic       mdu_isDiv;
  logic       E_isMdu;
  logic [4:0] M_excCode;
  logic       M_isEret;
  logic       M_valid;
  logic       intPending;
  logic       F_en;
  logic       D_en;
  logic       E_flush;
  logic       flushAll;
  logic [1:0] pc_sel;
  logic       cp0_we_exc;
  logic       mdu_busy;
  logic [1:0] state;

  // Pipeline side: reports hazards and events, consumes enables.
  modport master (
    output hazard_stall, mdu_start, mdu_isDiv, E_isMdu,
           M_excCode, M_isEret, M_valid, intPending,
    input  F_en, D_en, E_flush, flushAll, pc_sel, cp0_we_exc, mdu_busy, state
  );

  // Controller side.
  modport slave (
    input  hazard_stall, mdu_start, mdu_isDiv, E_isMdu,
           M_excCode, M_isEret, M_valid, intPending,
    output F_en, D_en, E_flush, flushAll, pc_sel, cp0_we_exc, mdu_busy, state
  );
endinterface

// File: rtl/pipe_ctrl_mdu_busy_counter.sv
// Multiply/divide occupancy countdown; busy while the count is nonzero.
module mdu_busy_counter #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic isDiv,
  input  logic cancel,
  output logic busy
);

  localparam int CW = $clog2(DIV_CYC + 1);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  // Next count: a running operation always finishes (cancel only blocks a new
  // load), and a start while busy is dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != {CW{1'b0}}) begin
      cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
    end else if (start && !cancel) begin
      cnt_d = isDiv ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != {CW{1'b0}});

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables, bubbles, global flush,
// next-PC select and exception/interrupt/ERET sequencing.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYC     = 5,
  parameter int DIV_CYC      = 10,
  parameter int INT_WAIT_MAX = 3
) (
  input  logic       clk,
  input  logic       reset,
  pipe_ctrl_if.slave bus
);

  localparam int WW = $clog2(INT_WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(INT_WAIT_MAX - 1);

  state_e        state_d;
  state_e        state_q;
  logic [WW-1:0] wait_d;
  logic [WW-1:0] wait_q;
  logic          take_s;
  logic          eret_s;
  logic          exc_s;
  logic          stall_s;
  logic          flush_s;
  logic          busy_s;
  logic          f_en_s;
  logic          d_en_s;
  logic          e_flush_s;
  logic [1:0]    pc_sel_s;

  assign exc_s = has_exc(bus.M_excCode);

  // Next-state and wait-counter logic; exceptions win in every state, and
  // ENTRY/RETURN mask interrupts and ERET for one cycle.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    take_s  = 1'b0;
    eret_s  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (exc_s || (bus.intPending && bus.M_valid)) begin
          take_s  = 1'b1;
          state_d = ST_ENTRY;
        end else if (bus.M_isEret) begin
          eret_s  = 1'b1;
          state_d = ST_RETURN;
        end else if (bus.intPending) begin
          state_d = ST_INT_WAIT;
          wait_d  = {WW{1'b0}};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_ENTRY, ST_RETURN: begin
        if (exc_s) begin
          take_s  = 1'b1;
          state_d = ST_ENTRY;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_INT_WAIT: begin
        if (exc_s) begin
          take_s  = 1'b1;
          state_d = ST_ENTRY;
        end else if (!bus.intPending) begin
          // Interrupt withdrawn: no entry, but an ERET that arrived in the
          // meantime must still be honoured rather than lost.
          if (bus.M_isEret) begin
            eret_s  = 1'b1;
            state_d = ST_RETURN;
          end else begin
            state_d = ST_RUN;
          end
        end else if (bus.M_valid || (wait_q == WAIT_LAST)) begin
          take_s  = 1'b1;
          state_d = ST_ENTRY;
        end else begin
          wait_d  = wait_q + {{(WW-1){1'b0}}, 1'b1};
          state_d = ST_INT_WAIT;
        end
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = {WW{1'b0}};
      end
    endcase
  end

  // FSM state and interrupt wait counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      wait_q  <= {WW{1'b0}};
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign flush_s = take_s || eret_s;
  assign stall_s = bus.hazard_stall || (bus.E_isMdu && (busy_s || bus.mdu_start));

  // Stage enables and bubble: a global flush overrides any stall so the
  // redirected fetch is not held off.
  always_comb begin
    f_en_s    = 1'b1;
    d_en_s    = 1'b1;
    e_flush_s = 1'b0;
    if (flush_s) begin
      f_en_s    = 1'b1;
      d_en_s    = 1'b1;
      e_flush_s = 1'b0;
    end else if (stall_s) begin
      f_en_s    = 1'b0;
      d_en_s    = 1'b0;
      e_flush_s = 1'b1;
    end else begin
      f_en_s    = 1'b1;
      d_en_s    = 1'b1;
      e_flush_s = 1'b0;
    end
  end

  // Next-PC select: handler entry beats ERET return.
  always_comb begin
    pc_sel_s = PC_SEQ;
    if (take_s) begin
      pc_sel_s = PC_HANDLER;
    end else if (eret_s) begin
      pc_sel_s = PC_EPC;
    end else begin
      pc_sel_s = PC_SEQ;
    end
  end

  mdu_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_mdu_cnt (
    .clk    (clk),
    .reset  (reset),
    .start  (bus.mdu_start),
    .isDiv  (bus.mdu_isDiv),
    .cancel (flush_s),
    .busy   (busy_s)
  );

  assign bus.F_en       = f_en_s;
  assign bus.D_en       = d_en_s;
  assign bus.E_flush    = e_flush_s;
  assign bus.flushAll   = flush_s;
  assign bus.pc_sel     = pc_sel_s;
  assign bus.cp0_we_exc = take_s;
  assign bus.mdu_busy   = busy_s;
  assign bus.state      = state_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencing controller for the five-stage MIPS core. It turns D-stage hazards, multiply/divide occupancy, M-stage exceptions, pending interrupts and ERET into per-stage enables, the E-stage bubble, the global flush (`intReq` to the pipeline registers) and the next-PC select. It owns the MDU busy countdown and a small FSM that masks interrupt re-entry for one cycle around exception entry and ERET.

## Interface
- `MULT_CYC`, default 5: busy cycles for mult/multu.
- `DIV_CYC`, default 10: busy cycles for div/divu.
- `INT_WAIT_MAX`, default 3: maximum cycles an interrupt waits for a valid M-stage instruction.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `hazard_stall` in 1: D-stage load-use or forwarding hazard.
- `mdu_start` in 1: E holds mult/multu/div/divu this cycle.
- `mdu_isDiv` in 1: qualifies `mdu_start`; 1 selects the divide latency.
- `E_isMdu` in 1: E holds an instruction needing the MDU (mfhi/mflo/mthi/mtlo/mult/div).
- `M_excCode` in 5: M-stage exception code; nonzero means an exception.
- `M_isEret` in 1: M holds ERET.
- `M_valid` in 1: M holds a real instruction, not a bubble.
- `intPending` in 1: CP0 interrupt request, already masked by IE/IM/EXL.
- `F_en` out 1: PC/F register enable.
- `D_en` out 1: D register enable.
- `E_flush` out 1: load a bubble into E.
- `flushAll` out 1: clear all pipeline registers; drives `intReq`.
- `pc_sel` out 2: 0 = sequential/branch, 1 = handler 0x0000_4180, 2 = EPC.
- `cp0_we_exc` out 1: one-cycle exception-entry strobe to CP0.
- `mdu_busy` out 1: MDU counter nonzero.
- `state` out 2: FSM state, for debug.

## Operation
- FSM states:
  - RUN (0): normal operation.
  - ENTRY (1): one cycle after exception or interrupt entry.
  - RETURN (2): one cycle after ERET.
  - INT_WAIT (3): interrupt held, waiting for a valid M instruction.
- In RUN, the take condition is `M_excCode != 0`, or `intPending && M_valid`.
  - Same cycle: `flushAll=1`, `pc_sel=1`, `cp0_we_exc=1`, `F_en=D_en=1`, `E_flush=0`.
  - Next state is ENTRY.
- Priority: exception > interrupt > ERET. An interrupt alongside an ERET in M is taken, and EPC is the ERET's PC.
- ERET in RUN with no take condition: `flushAll=1`, `pc_sel=2`; next state RETURN.
- ENTRY and RETURN:
  - `intPending` and `M_isEret` are ignored.
  - `M_excCode != 0` is still taken. It cannot occur after a flush, but the path is defined.
  - Return to RUN after one cycle.
- RUN with `intPending && !M_valid` and no exception: go to INT_WAIT and clear the wait counter.
- INT_WAIT:
  - Take on `M_valid`, or when the counter equals `INT_WAIT_MAX-1`; then go to ENTRY.
  - Exceptions are still taken immediately.
  - If `intPending` drops, return to RUN with no take.
  - Normal stalls apply while waiting.
- Stall condition: `hazard_stall || (E_isMdu && (mdu_busy || mdu_start))`. When it holds, `F_en=D_en=0` and `E_flush=1`.
- `flushAll` dominates any stall: enables forced to 1 and `E_flush=0`.
- MDU counter:
  - Width is `$clog2(DIV_CYC+1)`.
  - When the count is 0 and `mdu_start` is high with no `flushAll`, load `mdu_isDiv ? DIV_CYC : MULT_CYC`.
  - A nonzero count decrements by 1 each cycle and saturates at 0.
  - `mdu_start` while busy is ignored; the count is unchanged.
  - A flush does not cancel a running operation.

## Timing
- All control outputs (`F_en`, `D_en`, `E_flush`, `flushAll`, `pc_sel`, `cp0_we_exc`) are combinational from the current state, counters and inputs. They have zero latency.
- `state`, the wait counter and the MDU counter are registered on the rising edge of `clk`.
- `mdu_busy` rises the cycle after an accepted `mdu_start`. It stays high for exactly MULT_CYC or DIV_CYC cycles.
- `cp0_we_exc` and `flushAll` are single-cycle pulses per event. Back-to-back takes are impossible because ENTRY masks interrupts.
- Values while `reset` is low, and immediately after release:
  - `state`=RUN, MDU counter=0, wait counter=0.
  - `F_en=D_en=1`, `E_flush=0`, `flushAll=0`, `pc_sel=0`, `cp0_we_exc=0`, `mdu_busy=0`.
- Asserting reset mid-division clears the counter and the FSM asynchronously.

## Structure
- `pipe_ctrl_pkg` holds:
  - the state encoding (RUN/ENTRY/RETURN/INT_WAIT);
  - the `pc_sel` codes;
  - the handler vector constant 32'h0000_4180;
  - the `EXC_NONE`=0 code.
- Sub-module `mdu_busy_counter` is parameterized by MULT_CYC/DIV_CYC. Ports: `clk`, `reset`, `start`, `isDiv`, `cancel` (tied to `flushAll`), `busy`.
- The FSM, wait counter and output logic live in `pipe_ctrl`.

## Test plan
- Reset release, then idle: all outputs at reset values. Pulse `mdu_start` with `mdu_isDiv=0` → `mdu_busy` high for exactly 5 cycles.
- Start a div, then `E_isMdu=1` held → `F_en=D_en=0` and `E_flush=1` for 10 cycles, releasing the cycle `mdu_busy` falls.
- `M_excCode=5'd4` together with `hazard_stall=1` → same cycle: `flushAll=1`, `pc_sel=1`, `cp0_we_exc=1`, `F_en=1`. `state`=ENTRY next cycle, RUN the cycle after.
- `intPending=1` with `M_valid=0` for 5 cycles → INT_WAIT, then forced take on the 3rd wait cycle. A second run with `M_valid` rising on wait cycle 1 → take that cycle.
- `M_isEret=1` → `pc_sel=2`, `flushAll=1`. `intPending=1` during the RETURN cycle is ignored and taken in the following RUN cycle when `M_valid=1`.
- `M_isEret=1` together with `intPending=1` and `M_valid=1` → `pc_sel=1` and `cp0_we_exc=1` (interrupt wins). Also assert `reset` mid-div → `mdu_busy=0` immediately.
